// File: rtl/ring_shift_ctr.sv
// ring_shift_ctr: WIDTH-bit ring (one-hot) / Johnson shift counter with parallel load,
// home-wrap pulse and illegal-state flag. Define RING_SELFCORRECT_EN to make a step from an illegal state return home.
module ring_shift_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    int cnt;
    cnt = 32'sd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + (v[i] ? 32'sd1 : 32'sd0);
    end
    return (cnt == 32'sd1);
  endfunction

  // A twisted-ring pattern has at most one boundary between adjacent differing bits.
  function automatic logic is_johnson(input logic [WIDTH-1:0] v);
    int edges;
    edges = 32'sd0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + ((v[i] != v[i+1]) ? 32'sd1 : 32'sd0);
    end
    return (edges <= 32'sd1);
  endfunction

  logic [WIDTH-1:0] out_r;
  logic             wrap_r;
  logic             err_s;
  logic             feed_r_s;
  logic             feed_l_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] next_out_s;
  logic             next_wrap_s;

  assign err_s = mode ? ~is_johnson(out_r) : ~is_onehot(out_r);
  assign out   = out_r;
  assign wrap  = wrap_r;
  assign err   = err_s;

  // Shifted value: the bit entering the vacated end is copied (ring) or inverted (Johnson).
  always_comb begin
    feed_r_s = out_r[0] ^ mode;
    feed_l_s = out_r[WIDTH-1] ^ mode;
    if (dir) begin
      shifted_s = {out_r[WIDTH-2:0], feed_l_s};
    end else begin
      shifted_s = {feed_r_s, out_r[WIDTH-1:1]};
    end
  end

  // Next state with load > step > hold priority; wrap only flags a step landing on home.
  always_comb begin
    next_out_s  = out_r;
    next_wrap_s = 1'b0;
    if (load) begin
      next_out_s  = load_val;
      next_wrap_s = 1'b0;
    end else if (en) begin
`ifdef RING_SELFCORRECT_EN
      if (err_s) begin
        next_out_s  = HOME;
        next_wrap_s = 1'b0;
      end else begin
        next_out_s  = shifted_s;
        next_wrap_s = (shifted_s == HOME);
      end
`else
      next_out_s  = shifted_s;
      next_wrap_s = (shifted_s == HOME);
`endif
    end else begin
      next_out_s  = out_r;
      next_wrap_s = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_r  <= HOME;
      wrap_r <= 1'b0;
    end else begin
      out_r  <= next_out_s;
      wrap_r <= next_wrap_s;
    end
  end

endmodule
